// File: rtl/pdm_capture_pkg.sv
// Shared types and defaults for the PDM capture block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pdm_capture_pkg;

    // Capture FSM: IDLE holds the counters cleared, ACCUM integrates events.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // PDM bits per PCM sample and the matching result width (0..DECIM).
    localparam int DECIM_DEF = 128;
    localparam int PCM_W_DEF = $clog2(DECIM_DEF + 1);

endpackage

// File: rtl/pdm_capture_edge_detect.sv
// Rise/fall detector for a level already synchronous to clk.
// Latency: combinational against a one-cycle-delayed copy of sig.
// Backpressure: none; pulses are single-cycle and unconditional.
// Ports: clk, reset (async, active-high), sig in; rise, fall single-cycle strobes out.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic clk_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_prev <= 1'b0;
        end else begin
            clk_prev <= sig;
        end
    end

    assign rise = sig & ~clk_prev;
    assign fall = ~sig & clk_prev;

endmodule

// File: rtl/pdm_capture.sv
// PDM-to-PCM capture: counts ones over DECIM microphone-clock edges.
// Latency: pcm_valid rises the cycle after the window's final edge.
// Backpressure: valid/ready; an unaccepted sample is overwritten and overrun sticks.
// Ports: CLK100MHZ, reset (async, active-high), clk_4MHz / pdm_data (mic interface,
//        already in the CLK100MHZ domain), enable level, pcm_ready in;
//        pcm_sample, pcm_valid, overrun (sticky until reset) out.
module pdm_capture
    import pdm_capture_pkg::*;
#(
    parameter int  DECIM    = DECIM_DEF,
    parameter int  EDGE_SEL = 0,
    localparam int PCM_W    = $clog2(DECIM + 1)
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             clk_4MHz,
    input  logic             pdm_data,
    input  logic             enable,
    input  logic             pcm_ready,
    output logic [PCM_W-1:0] pcm_sample,
    output logic [0:0]       pcm_valid,
    output logic             overrun
);

    localparam logic [PCM_W-1:0] LAST_BIT = PCM_W'(DECIM - 1);

    state_t           state;
    logic [PCM_W-1:0] bit_cnt;
    logic [PCM_W-1:0] ones_cnt;
    logic             clk_rise;
    logic             clk_fall;
    logic             pdm_evt;

    edge_detect u_edge (
        .clk   (CLK100MHZ),
        .reset (reset),
        .sig   (clk_4MHz),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    // The microphone drives data on one clock edge; sample on the selected one.
    assign pdm_evt = (EDGE_SEL != 0) ? clk_fall : clk_rise;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            pcm_sample <= '0;
            pcm_valid  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Acceptance drops valid; a completion below overrides this.
            if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    ones_cnt <= '0;
                    if (enable) begin
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (!enable) begin
                        // Partial window (including a completing edge this cycle) is dropped.
                        state    <= IDLE;
                        bit_cnt  <= '0;
                        ones_cnt <= '0;
                    end else if (pdm_evt) begin
                        if (bit_cnt == LAST_BIT) begin
                            // ones_cnt <= DECIM-1 here, so the sum fits PCM_W without wrap.
                            pcm_sample <= ones_cnt + PCM_W'(pdm_data);
                            pcm_valid  <= 1'b1;
                            if (pcm_valid && !pcm_ready) begin
                                overrun <= 1'b1;
                            end
                            bit_cnt  <= '0;
                            ones_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (pdm_data) begin
                                ones_cnt <= ones_cnt + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pdm_capture.sv
// Self-checking bench for pdm_capture (DECIM=128, rising-edge sampling).
// Latency: n/a.
// Backpressure: bench drives pcm_ready directly.
module tb_pdm_capture;

    logic       CLK100MHZ;
    logic       reset;
    logic       clk_4MHz;
    logic       pdm_data;
    logic       enable;
    logic       pcm_ready;
    logic [7:0] pcm_sample;
    logic [0:0] pcm_valid;
    logic       overrun;

    pdm_capture #(.DECIM(128), .EDGE_SEL(0)) dut (
        .CLK100MHZ  (CLK100MHZ),
        .reset      (reset),
        .clk_4MHz   (clk_4MHz),
        .pdm_data   (pdm_data),
        .enable     (enable),
        .pcm_ready  (pcm_ready),
        .pcm_sample (pcm_sample),
        .pcm_valid  (pcm_valid),
        .overrun    (overrun)
    );

    initial begin
        CLK100MHZ = 1'b0;
        forever #5 CLK100MHZ = ~CLK100MHZ;
    end

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];

    int   phase = 0;
    int   cyc   = 0;
    int   ev    = 0;
    int   mode  = 0;
    logic alt   = 1'b1;
    bit   rdy_at_rise = 1'b0;
    bit   en_off_at_rise = 1'b0;
    int   vcnt  = 0;
    logic vprev = 1'b0;
    int   vrise[$];

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Monitor: sample away from the edge; a handshake at the next posedge pops the scoreboard.
    initial begin
        logic [7:0] want;
        forever begin
            @(negedge CLK100MHZ);
            if (!reset && pcm_valid[0] && pcm_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_sample got=%0d want=none", pcm_sample);
                end else begin
                    want = exp_q.pop_front();
                    if (pcm_sample !== want) begin
                        bad++;
                        $display("FAIL pcm_sample got=%0d want=%0d", pcm_sample, want);
                    end
                end
            end
        end
    end

    // One CLK100MHZ cycle of stimulus; clk_4MHz has a 32-cycle period (16 low / 16 high).
    task automatic step();
        @(posedge CLK100MHZ);
        #2;
        cyc++;
        if (pcm_valid[0]) vcnt++;
        if (pcm_valid[0] && !vprev) vrise.push_back(cyc);
        vprev = pcm_valid[0];
        phase = (phase + 1) % 32;
        if (phase == 16) begin
            clk_4MHz = 1'b1;
            case (mode)
                0:       pdm_data = 1'b0;
                1:       pdm_data = 1'b1;
                default: begin pdm_data = alt; alt = ~alt; end
            endcase
            ev++;
            if (rdy_at_rise)    begin pcm_ready = 1'b1; rdy_at_rise = 1'b0; end
            if (en_off_at_rise) begin enable = 1'b0; en_off_at_rise = 1'b0; end
        end else if (phase == 0) begin
            clk_4MHz = 1'b0;
        end
    endtask

    task automatic run_events(input int n);
        int target;
        target = ev + n;
        while (ev < target) step();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Align to the low half so the next rising edge is the first one seen in ACCUM.
    task automatic to_low_phase();
        while (phase != 2) step();
    endtask

    initial begin
        reset = 1'b0; clk_4MHz = 1'b0; pdm_data = 1'b0; enable = 1'b0; pcm_ready = 1'b0;

        // Reset state
        #3 reset = 1'b1;
        #1;
        check("rst_valid", pcm_valid, 0);
        check("rst_sample", pcm_sample, 0);
        check("rst_overrun", overrun, 0);
        steps(5);
        to_low_phase();
        reset = 1'b0;

        // All ones, ready held: 128 per window, one-cycle valid, 4096-cycle spacing
        enable = 1'b1; pcm_ready = 1'b1; mode = 1;
        vcnt = 0; vrise.delete();
        exp_q.push_back(8'd128);
        exp_q.push_back(8'd128);
        run_events(256);
        steps(4);
        check("valid_cycles", vcnt, 2);
        check("period", (vrise.size() == 2) ? vrise[1] - vrise[0] : -1, 4096);
        check("no_overrun_t1", overrun, 0);

        // Alternating bits -> 64, all zeros -> 0
        mode = 2; alt = 1'b1;
        exp_q.push_back(8'd64);
        run_events(128);
        mode = 0;
        exp_q.push_back(8'd0);
        run_events(128);
        steps(4);
        check("queue_drained_t2", exp_q.size(), 0);

        // Partial window of ones abandoned; fresh window of zeros must read 0
        mode = 1;
        run_events(50);
        step();
        enable = 1'b0;
        steps(10);
        to_low_phase();
        enable = 1'b1; mode = 0;
        exp_q.push_back(8'd0);
        run_events(128);
        steps(4);

        // enable dropped on the completing edge: no sample
        mode = 1;
        vcnt = 0;
        run_events(127);
        en_off_at_rise = 1'b1;
        run_events(1);
        steps(40);
        check("discard_on_disable", vcnt, 0);

        // Ready raised in the exact completion cycle with an old sample pending
        to_low_phase();
        enable = 1'b1; pcm_ready = 1'b0; mode = 0;
        exp_q.push_back(8'd0);
        run_events(128);
        mode = 1;
        exp_q.push_back(8'd128);
        run_events(127);
        rdy_at_rise = 1'b1;
        run_events(1);
        step();
        check("same_cycle_valid", pcm_valid, 1);
        check("same_cycle_sample", pcm_sample, 128);
        check("same_cycle_overrun", overrun, 0);
        steps(4);

        // Two completions without ready: overwrite and sticky overrun
        pcm_ready = 1'b0; mode = 1;
        run_events(128);
        steps(2);
        check("ovr_first_valid", pcm_valid, 1);
        check("ovr_first_flag", overrun, 0);
        mode = 2; alt = 1'b1;
        run_events(128);
        steps(2);
        check("ovr_second_valid", pcm_valid, 1);
        check("ovr_flag", overrun, 1);
        exp_q.push_back(8'd64);
        pcm_ready = 1'b1;
        steps(3);
        check("ovr_valid_dropped", pcm_valid, 0);
        steps(40);
        check("ovr_sticky", overrun, 1);

        // Reset mid-window with a sample pending
        pcm_ready = 1'b0; mode = 1;
        run_events(128);
        steps(2);
        run_events(60);
        step();
        reset = 1'b1;
        #1;
        check("async_rst_valid", pcm_valid, 0);
        check("async_rst_sample", pcm_sample, 0);
        check("async_rst_overrun", overrun, 0);
        steps(3);
        to_low_phase();
        reset = 1'b0;
        pcm_ready = 1'b1;
        exp_q.push_back(8'd128);
        run_events(128);
        steps(5);
        check("post_rst_overrun", overrun, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
